// File: rtl/snake_px_pkg.sv
// rtl/snake_px_pkg.sv - shared types, constants and address helper for the snake pixel cell writer
package snake_px_pkg;

    localparam int PX_X_SHIFT = 1;
    localparam int PX_Y_SHIFT = 10;
    localparam int SCREEN_W   = 320;
    localparam int SCREEN_H   = 240;

    localparam logic [15:0] COLOR_SNAKE = 16'hFF00;
    localparam logic [15:0] COLOR_APPLE = 16'h00FF;
    localparam logic [15:0] COLOR_BG    = 16'h0000;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE
    } px_state_t;

    typedef struct packed {
        logic [6:0]  x;
        logic [5:0]  y;
        logic [15:0] color;
    } px_req_t;

    function automatic logic [31:0] px_addr(input logic [31:0] base,
                                            input logic [8:0]  px,
                                            input logic [7:0]  py);
        return base | ({24'd0, py} << PX_Y_SHIFT) | ({23'd0, px} << PX_X_SHIFT);
    endfunction

endpackage

// File: rtl/snake_px_req_fifo.sv
// rtl/snake_px_req_fifo.sv - synchronous request queue of px_req_t with read/write pointers and occupancy count
module snake_px_req_fifo
    import snake_px_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  logic    pop,
    input  px_req_t din,
    output px_req_t dout,
    output logic    full,
    output logic    empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    px_req_t       mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == FULL_COUNT);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Simultaneous push and pop leave occupancy unchanged.
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/snake_px_cell_writer.sv
// rtl/snake_px_cell_writer.sv - queues cell draw requests and expands each into CELL_SIZE^2 Avalon pixel writes; SNAKE_PX_BOUNDS_CHECK_EN enables dropping out-of-grid requests
module snake_px_cell_writer
    import snake_px_pkg::*;
#(
    parameter int          CELL_SIZE  = 4,
    parameter int          GRID_W     = 80,
    parameter int          GRID_H     = 60,
    parameter logic [31:0] PX_BASE    = 32'hC800_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [6:0]  req_x,
    input  logic [5:0]  req_y,
    input  logic [15:0] req_color,
    output logic        busy,
    output logic        err_oob,
    output logic [31:0] vga_px_address,
    output logic        vga_px_write,
    output logic [15:0] vga_px_writedata,
    output logic        vga_px_read,
    input  logic        vga_px_waitrequest
);

    localparam logic [2:0] LAST = 3'(CELL_SIZE - 1);

`ifdef SNAKE_PX_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    px_state_t   state_q, state_d;
    logic [8:0]  bx_q, bx_d;
    logic [7:0]  by_q, by_d;
    logic [2:0]  dx_q, dx_d;
    logic [2:0]  dy_q, dy_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [15:0] data_q, data_d;

    logic        fifo_full, fifo_empty, fifo_push, fifo_pop;
    px_req_t     fifo_din, fifo_dout;
    logic        head_oob;
    logic [8:0]  head_bx;
    logic [7:0]  head_by;

    assign fifo_din  = '{x: req_x, y: req_y, color: req_color};
    assign req_ready = !fifo_full;
    assign fifo_push = req_valid && !fifo_full;

    snake_px_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_bx  = 9'(32'(fifo_dout.x) * 32'(CELL_SIZE));
    assign head_by  = 8'(32'(fifo_dout.y) * 32'(CELL_SIZE));
    assign head_oob = BOUNDS_EN &&
                      ((32'(fifo_dout.x) >= 32'(GRID_W)) || (32'(fifo_dout.y) >= 32'(GRID_H)));
    assign err_oob  = (state_q == LOAD) && !fifo_empty && head_oob;

    always_comb begin
        state_d  = state_q;
        bx_d     = bx_q;
        by_d     = by_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        addr_d   = addr_q;
        write_d  = write_q;
        data_d   = data_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // A dropped request re-enters LOAD; an empty queue there just falls back to IDLE.
                if (fifo_empty) begin
                    state_d = IDLE;
                end else begin
                    fifo_pop = 1'b1;
                    if (head_oob) begin
                        state_d = LOAD;
                    end else begin
                        bx_d    = head_bx;
                        by_d    = head_by;
                        dx_d    = 3'd0;
                        dy_d    = 3'd0;
                        addr_d  = px_addr(PX_BASE, head_bx, head_by);
                        data_d  = fifo_dout.color;
                        write_d = 1'b1;
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                if (write_q && !vga_px_waitrequest) begin
                    if (dx_q == LAST && dy_q == LAST) begin
                        write_d = 1'b0;
                        state_d = fifo_empty ? IDLE : LOAD;
                    end else begin
                        if (dx_q != LAST) begin
                            dx_d = dx_q + 3'd1;
                        end else begin
                            dx_d = 3'd0;
                            dy_d = dy_q + 3'd1;
                        end
                        addr_d = px_addr(PX_BASE, bx_q + {6'd0, dx_d}, by_q + {5'd0, dy_d});
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bx_q    <= '0;
            by_q    <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            data_q  <= data_d;
        end
    end

    assign busy             = (state_q != IDLE) || !fifo_empty;
    assign vga_px_address   = addr_q;
    assign vga_px_write     = write_q;
    assign vga_px_writedata = data_q;
    assign vga_px_read      = 1'b0;

endmodule

// File: tb/tb_snake_px_cell_writer.sv
// tb/tb_snake_px_cell_writer.sv - directed table-driven bench for snake_px_cell_writer
module tb_snake_px_cell_writer;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  req_x;
    logic [5:0]  req_y;
    logic [15:0] req_color;
    logic        busy;
    logic        err_oob;
    logic [31:0] vga_px_address;
    logic        vga_px_write;
    logic [15:0] vga_px_writedata;
    logic        vga_px_read;
    logic        vga_px_waitrequest;

    snake_px_cell_writer dut (
        .clk                (clk),
        .reset              (reset),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_x              (req_x),
        .req_y              (req_y),
        .req_color          (req_color),
        .busy               (busy),
        .err_oob            (err_oob),
        .vga_px_address     (vga_px_address),
        .vga_px_write       (vga_px_write),
        .vga_px_writedata   (vga_px_writedata),
        .vga_px_read        (vga_px_read),
        .vga_px_waitrequest (vga_px_waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  x;
        logic [5:0]  y;
        logic [15:0] c;
        int          stall_at;
        int          stall_len;
        logic [31:0] first_a;
        logic [31:0] last_a;
        int          exp_whi;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] got_a[$];
    logic [15:0] got_d[$];
    int          whi, gaps, errs, first_w, last_w, done_idx, stall_bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_addr(input int cx, input int cy, input int k);
        return 32'hC800_0000 + 32'((cy * 4 + k / 4) * 1024 + (cx * 4 + k % 4) * 2);
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 1'b0;
        vga_px_waitrequest = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send(input logic [6:0] x, input logic [5:0] y, input logic [15:0] c);
        req_x = x;
        req_y = y;
        req_color = c;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic collect(input int stall_at, input int stall_len, input int budget);
        int          left;
        bit          stalling;
        logic [31:0] hold_a;
        logic [15:0] hold_d;
        got_a.delete();
        got_d.delete();
        whi = 0; gaps = 0; errs = 0; first_w = -1; last_w = -1; done_idx = -1; stall_bad = 0;
        left = stall_len;
        stalling = 1'b0;
        hold_a = '0;
        hold_d = '0;
        for (int i = 0; i < budget; i++) begin
            if (vga_px_write && got_a.size() == stall_at && left > 0) begin
                if (stalling && (vga_px_address !== hold_a || vga_px_writedata !== hold_d))
                    stall_bad++;
                vga_px_waitrequest = 1'b1;
                left--;
                stalling = 1'b1;
                hold_a = vga_px_address;
                hold_d = vga_px_writedata;
            end else begin
                if (stalling && (vga_px_write !== 1'b1 || vga_px_address !== hold_a ||
                                 vga_px_writedata !== hold_d))
                    stall_bad++;
                stalling = 1'b0;
                vga_px_waitrequest = 1'b0;
            end
            if (vga_px_write) begin
                whi++;
                if (first_w < 0) first_w = i;
                else if (last_w < i - 1) gaps += i - 1 - last_w;
                last_w = i;
                if (!vga_px_waitrequest) begin
                    got_a.push_back(vga_px_address);
                    got_d.push_back(vga_px_writedata);
                end
            end
            if (err_oob) errs++;
            if (!busy) begin
                done_idx = i;
                return;
            end
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL collect_timeout actual=busy required=idle within %0d cycles", budget);
    endtask

    vec_t vecs[5];
    int   mism;
    int   n;
    bit   rdy_seen;

    initial begin
        vecs[0] = '{7'd2,  6'd3,  16'hFF00, -1, 0, 32'hC800_3010, 32'hC800_3C16, 16};
        vecs[1] = '{7'd2,  6'd3,  16'hFF00,  5, 3, 32'hC800_3010, 32'hC800_3C16, 19};
        vecs[2] = '{7'd0,  6'd0,  16'h00FF, -1, 0, 32'hC800_0000, 32'hC800_0C06, 16};
        vecs[3] = '{7'd79, 6'd59, 16'h0000,  0, 2, 32'hC803_B278, 32'hC803_BE7E, 18};
        vecs[4] = '{7'd10, 6'd20, 16'h1234, 15, 1, 32'hC801_4050, 32'hC801_4C56, 17};

        req_x = '0; req_y = '0; req_color = '0;
        do_reset();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_write", 32'(vga_px_write), 32'd0);
        chk("rst_address", vga_px_address, 32'd0);
        chk("rst_writedata", 32'(vga_px_writedata), 32'd0);
        chk("rst_err_oob", 32'(err_oob), 32'd0);
        chk("rst_read", 32'(vga_px_read), 32'd0);

        for (int v = 0; v < 5; v++) begin
            do_reset();
            send(vecs[v].x, vecs[v].y, vecs[v].c);
            collect(vecs[v].stall_at, vecs[v].stall_len, 200);
            chk($sformatf("v%0d_latency", v), 32'(first_w), 32'd2);
            chk($sformatf("v%0d_beats", v), 32'(got_a.size()), 32'd16);
            chk($sformatf("v%0d_write_cycles", v), 32'(whi), 32'(vecs[v].exp_whi));
            if (got_a.size() == 16) begin
                chk($sformatf("v%0d_first_addr", v), got_a[0], vecs[v].first_a);
                chk($sformatf("v%0d_last_addr", v), got_a[15], vecs[v].last_a);
                mism = 0;
                for (int k = 0; k < 16; k++) begin
                    if (got_a[k] !== model_addr(int'(vecs[v].x), int'(vecs[v].y), k)) mism++;
                    if (got_d[k] !== vecs[v].c) mism++;
                end
                chk($sformatf("v%0d_beat_seq", v), 32'(mism), 32'd0);
            end
            chk($sformatf("v%0d_busy_drop", v), 32'(done_idx), 32'(last_w + 1));
            chk($sformatf("v%0d_err_oob", v), 32'(errs), 32'd0);
            if (vecs[v].stall_len > 0)
                chk($sformatf("v%0d_stall_stable", v), 32'(stall_bad), 32'd0);
        end

        // Backpressure: stall the bus while six requests are offered back-to-back.
        do_reset();
        vga_px_waitrequest = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_x = 7'(i);
            req_y = 6'd0;
            req_color = 16'h1000 + 16'(i);
            req_valid = 1'b1;
            rdy_seen = req_ready;
            chk($sformatf("bp_ready_%0d", i), 32'(rdy_seen), (i < 5) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("bp_stalled_write", 32'(vga_px_write), 32'd1);
        chk("bp_stalled_addr", vga_px_address, 32'hC800_0000);
        collect(-1, 0, 500);
        chk("bp_beats", 32'(got_a.size()), 32'd80);
        chk("bp_gaps", 32'(gaps), 32'd4);
        if (got_a.size() == 80) begin
            mism = 0;
            for (int k = 0; k < 80; k++) begin
                if (got_a[k] !== model_addr(k / 16, 0, k % 16)) mism++;
                if (got_d[k] !== 16'h1000 + 16'(k / 16)) mism++;
            end
            chk("bp_fifo_order", 32'(mism), 32'd0);
        end

        // Out-of-grid request followed by a legal one.
        do_reset();
        send(7'd80, 6'd0, 16'hFF00);
        send(7'd0, 6'd0, 16'h00FF);
        collect(-1, 0, 200);
`ifdef SNAKE_PX_BOUNDS_CHECK_EN
        chk("oob_err_cycles", 32'(errs), 32'd1);
        chk("oob_beats", 32'(got_a.size()), 32'd16);
        if (got_a.size() > 0) chk("oob_next_first", got_a[0], 32'hC800_0000);
        if (got_d.size() > 0) chk("oob_next_data", 32'(got_d[0]), 32'h00FF);
`else
        chk("oob_err_cycles", 32'(errs), 32'd0);
        chk("oob_beats", 32'(got_a.size()), 32'd32);
        if (got_a.size() > 16) begin
            chk("oob_first", got_a[0], 32'hC800_0280);
            chk("oob_second_first", got_a[16], 32'hC800_0000);
        end
`endif

        // Reset while beat 7 of a cell is on the bus.
        do_reset();
        send(7'd2, 6'd3, 16'hFF00);
        n = 0;
        for (int i = 0; i < 40 && n < 7; i++) begin
            if (vga_px_write) n++;
            @(negedge clk);
        end
        chk("mid_beat7_addr", vga_px_address, 32'hC800_3416);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_write", 32'(vga_px_write), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_req_ready", 32'(req_ready), 32'd1);
        send(7'd0, 6'd0, 16'h00FF);
        collect(-1, 0, 200);
        chk("mid_new_beats", 32'(got_a.size()), 32'd16);
        if (got_a.size() > 0) chk("mid_new_first", got_a[0], 32'hC800_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
